com_sched: RTL and testbench
============================

// Module: com_sched
// PURPOSE
//  Frame scheduler in front of com. Periodically sequences one outbound frame: starts the data filler
//  (writes ram_data), then starts com's send path, each via fs/fd handshake, with per-phase timeout.
//  Replaces ad-hoc top-level sequencing FSMs; sits in the clk_norm domain between console and com.
// PARAMETERS
//  PERIOD_W   32             width of period/timeout counters
//  TIMEOUT    32'd75_000_000 max cycles in FILL or SEND before abort (clk_norm cycles)
//  DLEN_W     13             width of data_len
//  BTYPE      4'h1           com_btype value driven during SEND
// PORTS
//  clk        in   1        clk_norm
//  rst_n      in   1        async active-low reset
//  enable     in   1        level; 1 = schedule frames
//  period     in   PERIOD_W cycles from DONE to next FILL; 0 = back-to-back
//  dlen_in    in   DLEN_W   frame payload length, sampled on entry to FILL
//  fs_fill    out  1        start to data filler
//  fd_fill    in   1        done from data filler
//  fs_send    out  1        start to com send path
//  fd_send    in   1        done from com send path
//  data_len   out  DLEN_W   latched payload length to com
//  com_btype  out  4        BTYPE in SEND, else 0
//  busy       out  1        1 in FILL/SEND/DONE
//  frame_cnt  out  16       frames completed, wraps 16'hFFFF->0
//  err_cnt    out  8        timeouts, saturates at 8'hFF
// BEHAVIOUR
//  Reset (rst_n=0, async): state IDLE; all outputs 0; counters 0.
//  Handshake: fs held high until fd seen high; fs drops the cycle after fd; fd high while fs low ignored.
//  States (one-hot): IDLE, WAIT, FILL, SEND, DONE, FAIL.
//   IDLE: enable=1 -> FILL next cycle (first frame has no period delay).
//   FILL: fs_fill=1; dlen_in latched into data_len on entry; timer cleared on entry.
//         fd_fill=1 -> SEND; timer==TIMEOUT-1 -> FAIL.
//   SEND: fs_send=1, com_btype=BTYPE; fd_send=1 -> DONE; timer==TIMEOUT-1 -> FAIL.
//   DONE: one cycle; frame_cnt++; -> WAIT (period!=0) or FILL (period==0 & enable) or IDLE (enable=0).
//   WAIT: timer counts 0..period-1; at period-1 -> FILL if enable else IDLE. period sampled on WAIT entry.
//   FAIL: one cycle; all fs low; err_cnt++ (sat); -> WAIT/IDLE as DONE (no frame_cnt++).
//  enable=0 mid-FILL/SEND: frame completes (or times out) normally; no new frame started.
//  fd and timeout in same cycle: fd wins (success).
//  fs outputs registered; rise one cycle after state entry is NOT allowed: fs asserted in first cycle of state.
//  data_len stable from FILL entry through DONE/FAIL; holds last value otherwise.
//  Timer single shared counter, cleared on every state change.
// TESTING
//  1 enable=1, period=10, fill done after 5 cyc, send after 20 -> fs_fill 5 cyc, fs_send 20 cyc, frame_cnt=1,
//    next fs_fill rises exactly 10 cyc after DONE.
//  2 period=0, fd returned 1 cyc after fs, 100 frames -> frame_cnt=100, no idle gaps beyond DONE cycle.
//  3 TIMEOUT=16 (override), fd_send never -> fs_send high 16 cyc, FAIL, err_cnt=1, frame_cnt unchanged;
//    300 timeouts -> err_cnt=8'hFF.
//  4 fd_send asserted on cycle TIMEOUT-1 -> DONE, err_cnt=0.
//  5 rst_n low mid-SEND -> all outputs 0 immediately (async), IDLE; release with enable=1 -> fresh FILL.
//  6 enable dropped in FILL, dlen_in changed mid-frame -> frame finishes with original data_len, then IDLE.

Source files
------------

// File: rtl/com_sched_if.sv
// -----------------------------------------------------------------------------
// com_sched_if
//  Start/done handshake bundle between the frame scheduler and its two
//  downstream engines (the data filler and com's send path). The bundle also
//  carries the payload length and block type that com needs while sending.
//
//  Signals
//   fs_fill    scheduler -> filler   start request, held until fd_fill
//   fd_fill    filler -> scheduler   done
//   fs_send    scheduler -> com      start request, held until fd_send
//   fd_send    com -> scheduler      done
//   data_len   scheduler -> com      payload length latched for this frame
//   com_btype  scheduler -> com      block type, non-zero only while sending
//
//  Modports
//   master     the scheduler side
//   slave      the filler / com side
// -----------------------------------------------------------------------------
interface com_sched_if #(
   parameter int DLEN_W = 13
);
   logic              fs_fill;
   logic              fd_fill;
   logic              fs_send;
   logic              fd_send;
   logic [DLEN_W-1:0] data_len;
   logic [3:0]        com_btype;

   modport master (
      output fs_fill,
      output fs_send,
      output data_len,
      output com_btype,
      input  fd_fill,
      input  fd_send
   );

   modport slave (
      input  fs_fill,
      input  fs_send,
      input  data_len,
      input  com_btype,
      output fd_fill,
      output fd_send
   );
endinterface

// File: rtl/com_sched.sv
// -----------------------------------------------------------------------------
// com_sched
//  Periodic frame scheduler sitting in front of com. For every frame it first
//  starts the data filler (which writes the frame RAM), then starts com's send
//  path, each through an fs/fd handshake. Each of the two phases is guarded by
//  a timeout; a timed-out frame is abandoned and counted as an error. Between
//  frames the scheduler waits a programmable number of cycles.
//
//  Ports
//   clk        clock (clk_norm domain)
//   rst_n      asynchronous active-low reset
//   enable     level; 1 = keep scheduling frames
//   period     idle cycles from end of a frame to the next fill; 0 = back-to-back
//   dlen_in    payload length, captured when a frame starts filling
//   bus        handshake bundle to filler and com (master side)
//   busy       high while a frame is in progress (FILL, SEND, DONE)
//   frame_cnt  completed frames, wraps
//   err_cnt    timed-out frames, saturates at 8'hFF
// -----------------------------------------------------------------------------
module com_sched #(
   parameter int                  PERIOD_W = 32,
   parameter logic [PERIOD_W-1:0] TIMEOUT  = PERIOD_W'(75_000_000),
   parameter int                  DLEN_W   = 13,
   parameter logic [3:0]          BTYPE    = 4'h1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [PERIOD_W-1:0] period,
   input  logic [DLEN_W-1:0]   dlen_in,
   com_sched_if.master         bus,
   output logic                busy,
   output logic [15:0]         frame_cnt,
   output logic [7:0]          err_cnt
);

   typedef enum logic [5:0] {
      S_IDLE = 6'b000001,
      S_WAIT = 6'b000010,
      S_FILL = 6'b000100,
      S_SEND = 6'b001000,
      S_DONE = 6'b010000,
      S_FAIL = 6'b100000
   } state_t;

   localparam logic [PERIOD_W-1:0] TIMEOUT_LAST = TIMEOUT - PERIOD_W'(1);

   state_t              state_reg, state_next;
   logic [PERIOD_W-1:0] timer_reg, timer_next;
   logic [PERIOD_W-1:0] period_reg, period_next;
   logic [PERIOD_W-1:0] period_last;
   logic [DLEN_W-1:0]   data_len_reg, data_len_next;
   logic [15:0]         frame_cnt_reg, frame_cnt_next;
   logic [7:0]          err_cnt_reg, err_cnt_next;
   logic                state_change;

   // WAIT is only entered with a non-zero period, so this never underflows
   // while it is being used.
   assign period_last  = period_reg - PERIOD_W'(1);
   assign state_change = (state_next != state_reg);

   // ---------------------------------------------------------------------
   // State register and datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         timer_reg     <= '0;
         period_reg    <= '0;
         data_len_reg  <= '0;
         frame_cnt_reg <= '0;
         err_cnt_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         timer_reg     <= timer_next;
         period_reg    <= period_next;
         data_len_reg  <= data_len_next;
         frame_cnt_reg <= frame_cnt_next;
         err_cnt_reg   <= err_cnt_next;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         S_IDLE: begin
            // First frame after enable goes straight to FILL, no period delay.
            if (enable) state_next = S_FILL;
         end
         S_WAIT: begin
            if (timer_reg == period_last) state_next = enable ? S_FILL : S_IDLE;
         end
         S_FILL: begin
            // Done is checked before the timeout so a late done still succeeds.
            if (bus.fd_fill)                  state_next = S_SEND;
            else if (timer_reg == TIMEOUT_LAST) state_next = S_FAIL;
         end
         S_SEND: begin
            if (bus.fd_send)                  state_next = S_DONE;
            else if (timer_reg == TIMEOUT_LAST) state_next = S_FAIL;
         end
         S_DONE, S_FAIL: begin
            if (!enable)                   state_next = S_IDLE;
            else if (period != '0)         state_next = S_WAIT;
            else                           state_next = S_FILL;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath next values
   // ---------------------------------------------------------------------
   always_comb begin
      // One shared timer, restarted on every state change.
      timer_next     = state_change ? '0 : timer_reg + PERIOD_W'(1);
      period_next    = period_reg;
      data_len_next  = data_len_reg;
      frame_cnt_next = frame_cnt_reg;
      err_cnt_next   = err_cnt_reg;

      // The wait length is frozen on WAIT entry so a reprogrammed period
      // only affects the next gap.
      if (state_change && state_next == S_WAIT) period_next = period;

      // Length is captured once per frame and held through DONE/FAIL.
      if (state_change && state_next == S_FILL) data_len_next = dlen_in;

      if (state_reg == S_DONE) frame_cnt_next = frame_cnt_reg + 16'd1;

      if (state_reg == S_FAIL && err_cnt_reg != 8'hFF) err_cnt_next = err_cnt_reg + 8'd1;
   end

   // ---------------------------------------------------------------------
   // Outputs: decoded straight from the one-hot state flops, so the starts
   // are glitch-free and high from the first cycle of their state.
   // ---------------------------------------------------------------------
   assign bus.fs_fill   = (state_reg == S_FILL);
   assign bus.fs_send   = (state_reg == S_SEND);
   assign bus.com_btype = (state_reg == S_SEND) ? BTYPE : 4'h0;
   assign bus.data_len  = data_len_reg;
   assign busy          = (state_reg == S_FILL) || (state_reg == S_SEND) || (state_reg == S_DONE);
   assign frame_cnt     = frame_cnt_reg;
   assign err_cnt       = err_cnt_reg;

endmodule

// File: tb/tb_com_sched.sv
// -----------------------------------------------------------------------------
// tb_com_sched
//  Directed bench for com_sched. A small responder plays the data filler and
//  com's send path: it raises fd in the Nth cycle that fs has been high
//  (N = fill_delay / send_delay, 0 = never answer). Inputs change and outputs
//  are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_com_sched;
   localparam int          PW         = 32;
   localparam int          DW         = 13;
   localparam int          TO         = 24;
   localparam logic [31:0] TB_TIMEOUT = 32'd24;
   localparam int          BOUND      = 200;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          enable  = 1'b0;
   logic [PW-1:0] period  = '0;
   logic [DW-1:0] dlen_in = '0;
   logic          busy;
   logic [15:0]   frame_cnt;
   logic [7:0]    err_cnt;

   int errors = 0;
   int checks = 0;

   int fill_delay = 0;
   int send_delay = 0;
   int fill_hi    = 0;
   int send_hi    = 0;

   com_sched_if #(.DLEN_W(DW)) ifc ();

   com_sched #(
      .PERIOD_W (PW),
      .TIMEOUT  (TB_TIMEOUT),
      .DLEN_W   (DW),
      .BTYPE    (4'h1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .period    (period),
      .dlen_in   (dlen_in),
      .bus       (ifc),
      .busy      (busy),
      .frame_cnt (frame_cnt),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   // Filler / send-path responder.
   always @(negedge clk) begin
      if (ifc.fs_fill) begin
         fill_hi = fill_hi + 1;
         ifc.fd_fill = (fill_delay != 0) && (fill_hi == fill_delay);
      end else begin
         fill_hi = 0;
         ifc.fd_fill = 1'b0;
      end
      if (ifc.fs_send) begin
         send_hi = send_hi + 1;
         ifc.fd_send = (send_delay != 0) && (send_hi == send_delay);
      end else begin
         send_hi = 0;
         ifc.fd_send = 1'b0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      rst_n  = 1'b0;
      enable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      enable = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (ifc.fs_fill !== 1'b0)   begin errors++; $display("FAIL reset_fs_fill: got %0b want 0", ifc.fs_fill); end
      checks++; if (ifc.fs_send !== 1'b0)   begin errors++; $display("FAIL reset_fs_send: got %0b want 0", ifc.fs_send); end
      checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
      checks++; if (ifc.data_len !== '0)    begin errors++; $display("FAIL reset_data_len: got %0d want 0", ifc.data_len); end
      checks++; if (ifc.com_btype !== 4'h0) begin errors++; $display("FAIL reset_btype: got %0h want 0", ifc.com_btype); end
      checks++; if (frame_cnt !== 16'd0)    begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
      checks++; if (err_cnt !== 8'd0)       begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0 || ifc.fs_fill !== 1'b0) begin errors++; $display("FAIL idle_hold: busy=%0b fs_fill=%0b want 0/0", busy, ifc.fs_fill); end
      $display("test_reset done: errors=%0d", errors);
   endtask

   // Fill 5 cycles, send 20 cycles, then a 10-cycle gap before the next fill.
   task automatic test_period();
      int n;
      int busy_in_wait;
      apply_reset();
      period = 10; fill_delay = 5; send_delay = 20; dlen_in = 13'd100;
      enable = 1'b1;
      @(negedge clk);
      checks++; if (ifc.data_len !== 13'd100) begin errors++; $display("FAIL p_data_len: got %0d want 100", ifc.data_len); end
      checks++; if (ifc.com_btype !== 4'h0)   begin errors++; $display("FAIL p_btype_fill: got %0h want 0", ifc.com_btype); end
      n = 0;
      while (ifc.fs_fill && n < BOUND) begin n++; @(negedge clk); end
      checks++; if (n != 5) begin errors++; $display("FAIL p_fill_len: got %0d cycles want 5", n); end
      checks++; if (ifc.com_btype !== 4'h1) begin errors++; $display("FAIL p_btype_send: got %0h want 1", ifc.com_btype); end
      n = 0;
      while (ifc.fs_send && n < BOUND) begin n++; @(negedge clk); end
      checks++; if (n != 20) begin errors++; $display("FAIL p_send_len: got %0d cycles want 20", n); end
      checks++; if (busy !== 1'b1 || ifc.fs_fill !== 1'b0) begin errors++; $display("FAIL p_done: busy=%0b fs_fill=%0b want 1/0", busy, ifc.fs_fill); end
      @(negedge clk);
      n = 0; busy_in_wait = 0;
      while (!ifc.fs_fill && n < BOUND) begin
         if (busy) busy_in_wait++;
         n++;
         @(negedge clk);
      end
      checks++; if (n != 10) begin errors++; $display("FAIL p_gap: got %0d cycles want 10", n); end
      checks++; if (busy_in_wait != 0) begin errors++; $display("FAIL p_wait_busy: got %0d busy cycles want 0", busy_in_wait); end
      checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL p_frame_cnt: got %0d want 1", frame_cnt); end
      checks++; if (err_cnt !== 8'd0)    begin errors++; $display("FAIL p_err_cnt: got %0d want 0", err_cnt); end
      $display("test_period done: errors=%0d", errors);
   endtask

   // period=0, 2-cycle fill and send: 100 frames in 500 cycles, never idle.
   task automatic test_back_to_back();
      int n;
      int gaps;
      apply_reset();
      period = 0; fill_delay = 2; send_delay = 2; dlen_in = 13'd8;
      enable = 1'b1;
      n = 0; gaps = 0;
      do begin
         @(negedge clk);
         n++;
         if (!busy) gaps++;
      end while (frame_cnt != 16'd100 && n < 2000);
      checks++; if (n != 501) begin errors++; $display("FAIL b2b_cycles: got %0d want 501", n); end
      checks++; if (gaps != 0) begin errors++; $display("FAIL b2b_gaps: got %0d idle cycles want 0", gaps); end
      enable = 1'b0;
      n = 0;
      while (busy && n < 50) begin n++; @(negedge clk); end
      checks++; if (frame_cnt !== 16'd101) begin errors++; $display("FAIL b2b_final_cnt: got %0d want 101", frame_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stop: busy=%0b want 0", busy); end
      $display("test_back_to_back done: errors=%0d", errors);
   endtask

   // Send path never answers: timeout after TO cycles, then saturation.
   task automatic test_timeout();
      int n;
      apply_reset();
      period = 0; fill_delay = 3; send_delay = 0; dlen_in = 13'd5;
      enable = 1'b1;
      @(negedge clk);
      n = 0;
      while (ifc.fs_fill && n < BOUND) begin n++; @(negedge clk); end
      n = 0;
      while (ifc.fs_send && n < BOUND) begin n++; @(negedge clk); end
      checks++; if (n != TO) begin errors++; $display("FAIL to_send_len: got %0d cycles want %0d", n, TO); end
      checks++; if (busy !== 1'b0 || ifc.fs_fill !== 1'b0) begin errors++; $display("FAIL to_fail_state: busy=%0b fs_fill=%0b want 0/0", busy, ifc.fs_fill); end
      @(negedge clk);
      checks++; if (err_cnt !== 8'd1)    begin errors++; $display("FAIL to_err_cnt: got %0d want 1", err_cnt); end
      checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL to_frame_cnt: got %0d want 0", frame_cnt); end
      checks++; if (ifc.fs_fill !== 1'b1) begin errors++; $display("FAIL to_retry: fs_fill=%0b want 1", ifc.fs_fill); end
      repeat (300 * (3 + TO + 1)) @(negedge clk);
      checks++; if (err_cnt !== 8'hFF)   begin errors++; $display("FAIL to_saturate: got %0d want 255", err_cnt); end
      checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL to_frame_cnt_end: got %0d want 0", frame_cnt); end
      $display("test_timeout done: errors=%0d", errors);
   endtask

   // fd_send arrives on the last allowed cycle: done must win over timeout.
   task automatic test_late_done();
      int n;
      apply_reset();
      period = 0; fill_delay = 2; send_delay = TO; dlen_in = 13'd9;
      enable = 1'b1;
      @(negedge clk);
      n = 0;
      while (ifc.fs_fill && n < BOUND) begin n++; @(negedge clk); end
      n = 0;
      while (ifc.fs_send && n < BOUND) begin n++; @(negedge clk); end
      checks++; if (n != TO) begin errors++; $display("FAIL late_send_len: got %0d cycles want %0d", n, TO); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL late_done_state: busy=%0b want 1", busy); end
      enable = 1'b0;
      @(negedge clk);
      checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL late_frame_cnt: got %0d want 1", frame_cnt); end
      checks++; if (err_cnt !== 8'd0)    begin errors++; $display("FAIL late_err_cnt: got %0d want 0", err_cnt); end
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL late_idle: busy=%0b want 0", busy); end
      $display("test_late_done done: errors=%0d", errors);
   endtask

   // Reset asserted mid-SEND clears outputs without waiting for a clock edge.
   task automatic test_async_reset();
      apply_reset();
      period = 0; fill_delay = 2; send_delay = 0; dlen_in = 13'd77;
      enable = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (ifc.fs_send !== 1'b1 || ifc.data_len !== 13'd77) begin errors++; $display("FAIL ar_in_send: fs_send=%0b data_len=%0d want 1/77", ifc.fs_send, ifc.data_len); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (ifc.fs_send !== 1'b0)   begin errors++; $display("FAIL ar_fs_send: got %0b want 0", ifc.fs_send); end
      checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL ar_busy: got %0b want 0", busy); end
      checks++; if (ifc.data_len !== '0)    begin errors++; $display("FAIL ar_data_len: got %0d want 0", ifc.data_len); end
      checks++; if (ifc.com_btype !== 4'h0) begin errors++; $display("FAIL ar_btype: got %0h want 0", ifc.com_btype); end
      @(negedge clk);
      dlen_in = 13'd55;
      rst_n   = 1'b1;
      @(negedge clk);
      checks++; if (ifc.fs_fill !== 1'b1 || ifc.data_len !== 13'd55) begin errors++; $display("FAIL ar_fresh_fill: fs_fill=%0b data_len=%0d want 1/55", ifc.fs_fill, ifc.data_len); end
      $display("test_async_reset done: errors=%0d", errors);
   endtask

   // enable and dlen_in change during FILL: frame completes with old length.
   task automatic test_enable_drop();
      int n;
      int bad_len;
      int rises;
      apply_reset();
      period = 4; fill_delay = 6; send_delay = 3; dlen_in = 13'd300;
      enable = 1'b1;
      @(negedge clk);
      @(negedge clk);
      enable  = 1'b0;
      dlen_in = 13'd999;
      n = 0; bad_len = 0;
      while (busy && n < 100) begin
         if (ifc.data_len !== 13'd300) bad_len++;
         n++;
         @(negedge clk);
      end
      checks++; if (n != 9)       begin errors++; $display("FAIL ed_frame_len: got %0d cycles want 9", n); end
      checks++; if (bad_len != 0) begin errors++; $display("FAIL ed_len_stable: got %0d bad cycles want 0", bad_len); end
      checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL ed_frame_cnt: got %0d want 1", frame_cnt); end
      rises = 0;
      repeat (12) begin
         @(negedge clk);
         if (ifc.fs_fill || busy) rises++;
      end
      checks++; if (rises != 0) begin errors++; $display("FAIL ed_no_restart: got %0d active cycles want 0", rises); end
      checks++; if (ifc.data_len !== 13'd300) begin errors++; $display("FAIL ed_len_hold: got %0d want 300", ifc.data_len); end
      $display("test_enable_drop done: errors=%0d", errors);
   endtask

   initial begin
      test_reset();
      test_period();
      test_back_to_back();
      test_timeout();
      test_late_done();
      test_async_reset();
      test_enable_drop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
